// File: rtl/xgmii_pkg.sv
// Shared XGMII control words and arbiter state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package xgmii_pkg;

   localparam logic [63:0] XGMII_IDLE_D = 64'h0707_0707_0707_0707;
   localparam logic [7:0]  XGMII_IDLE_C = 8'hFF;
   localparam logic [63:0] XGMII_ERR_D  = 64'hFEFE_FEFE_FEFE_FEFE;
   localparam logic [7:0]  XGMII_ERR_C  = 8'hFF;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2,
      IPG    = 2'd3
   } arb_state_t;

endpackage

// File: rtl/xgmii_rr_pick.sv
// Two-way round-robin pick: on a tie the requester not granted most recently wins.
// Latency: combinational; gnt is only meaningful while req is non-zero.
// Backpressure: n/a.
module xgmii_rr_pick (
   input  logic [1:0] req,
   input  logic       last_gnt,
   output logic       gnt
);

   always_comb begin
      gnt = req[1];
      if (req == 2'b11) begin
         gnt = ~last_gnt;
      end
   end

endmodule

// File: rtl/xgmii_tx_arb.sv
// Two framed requesters share one half-rate XGMII slot stream; XGMII_ARB_STATS_EN adds per-port frame counters.
// Latency: a word accepted in a pre-slot cycle is on xgmii_txd_o/xgmii_txc_o in the following slot cycle.
// Backpressure: sN_ready_o only in pre-slot cycles of the granted port; a missing word mid-frame becomes an error slot.
module xgmii_tx_arb
   import xgmii_pkg::*;
#(
   parameter int IPG_WORDS = 1
) (
   input  logic        tx_user_clk,
   input  logic        tx_user_rst,
   input  logic [63:0] s0_txd_i,
   input  logic [7:0]  s0_txc_i,
   input  logic        s0_valid_i,
   input  logic        s0_last_i,
   output logic        s0_ready_o,
   input  logic [63:0] s1_txd_i,
   input  logic [7:0]  s1_txc_i,
   input  logic        s1_valid_i,
   input  logic        s1_last_i,
   output logic        s1_ready_o,
   output logic [63:0] xgmii_txd_o,
   output logic [7:0]  xgmii_txc_o,
   output logic        xgmii_txd_vld_o,
`ifdef XGMII_ARB_STATS_EN
   output logic [31:0] frame_cnt0_o,
   output logic [31:0] frame_cnt1_o,
`endif
   output logic        underrun_o
);

   localparam logic [3:0] IPG_LOAD = 4'(IPG_WORDS);

   arb_state_t  state_q, state_d;
   logic [3:0]  ipg_cnt_q, ipg_cnt_d;
   logic        rr_last_q, rr_last_d;
   logic [63:0] txd_d;
   logic [7:0]  txc_d;
   logic        underrun_d;
   logic        pre_slot;
   logic        pick;
   logic        sel_port;
   logic        sel_valid;
   logic        sel_last;
   logic [63:0] sel_txd;
   logic [7:0]  sel_txc;

   assign pre_slot = ~xgmii_txd_vld_o & ~tx_user_rst;

   assign s0_ready_o = pre_slot & (state_q == GRANT0);
   assign s1_ready_o = pre_slot & (state_q == GRANT1);

   assign sel_port  = (state_q == GRANT1);
   assign sel_valid = sel_port ? s1_valid_i : s0_valid_i;
   assign sel_last  = sel_port ? s1_last_i  : s0_last_i;
   assign sel_txd   = sel_port ? s1_txd_i   : s0_txd_i;
   assign sel_txc   = sel_port ? s1_txc_i   : s0_txc_i;

   xgmii_rr_pick u_rr_pick (
      .req      ({s1_valid_i, s0_valid_i}),
      .last_gnt (rr_last_q),
      .gnt      (pick)
   );

   always_comb begin
      state_d    = state_q;
      ipg_cnt_d  = ipg_cnt_q;
      rr_last_d  = rr_last_q;
      txd_d      = XGMII_IDLE_D;
      txc_d      = XGMII_IDLE_C;
      underrun_d = 1'b0;
      if (pre_slot) begin
         unique case (state_q)
            IDLE: begin
               if (s0_valid_i | s1_valid_i) begin
                  state_d   = pick ? GRANT1 : GRANT0;
                  rr_last_d = pick;
               end
            end
            GRANT0, GRANT1: begin
               if (sel_valid) begin
                  txd_d = sel_txd;
                  txc_d = sel_txc;
                  if (sel_last) begin
                     state_d   = (IPG_WORDS == 0) ? IDLE : IPG;
                     ipg_cnt_d = IPG_LOAD;
                  end
               end else begin
                  txd_d      = XGMII_ERR_D;
                  txc_d      = XGMII_ERR_C;
                  underrun_d = 1'b1;
               end
            end
            IPG: begin
               ipg_cnt_d = ipg_cnt_q - 4'd1;
               if (ipg_cnt_q <= 4'd1) begin
                  state_d   = IDLE;
                  ipg_cnt_d = 4'd0;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // rr_last_q remembers the last granted port; resetting it to 1 hands port 0 the first tie.
   always_ff @(posedge tx_user_clk) begin
      if (tx_user_rst) begin
         state_q         <= IDLE;
         ipg_cnt_q       <= 4'd0;
         rr_last_q       <= 1'b1;
         xgmii_txd_vld_o <= 1'b0;
         xgmii_txd_o     <= XGMII_IDLE_D;
         xgmii_txc_o     <= XGMII_IDLE_C;
         underrun_o      <= 1'b0;
      end else begin
         state_q         <= state_d;
         ipg_cnt_q       <= ipg_cnt_d;
         rr_last_q       <= rr_last_d;
         xgmii_txd_vld_o <= ~xgmii_txd_vld_o;
         underrun_o      <= underrun_d;
         if (pre_slot) begin
            xgmii_txd_o <= txd_d;
            xgmii_txc_o <= txc_d;
         end
      end
   end

`ifdef XGMII_ARB_STATS_EN
   always_ff @(posedge tx_user_clk) begin
      if (tx_user_rst) begin
         frame_cnt0_o <= 32'd0;
         frame_cnt1_o <= 32'd0;
      end else begin
         if (s0_ready_o && s0_valid_i && s0_last_i) begin
            frame_cnt0_o <= frame_cnt0_o + 32'd1;
         end
         if (s1_ready_o && s1_valid_i && s1_last_i) begin
            frame_cnt1_o <= frame_cnt1_o + 32'd1;
         end
      end
   end
`endif

endmodule
